// File: rtl/cpu_pc.sv
// Program counter for the MIPS fetch stage with a single branch-delay slot:
// a taken branch is remembered for one enabled cycle so the delay-slot instruction is fetched first.
module cpu_pc #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wen,
    input  logic        b_cond_met,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_o
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] target_reg;
    logic [31:0] target_next;
    logic        pending_reg;
    logic        pending_next;
    logic [31:0] pc_seq;

    // 32-bit modulo increment; wraps from FFFFFFFC to 00000000.
    assign pc_seq = pc_reg + PC_STEP;

    always_comb begin
        pc_next      = pc_reg;
        target_next  = target_reg;
        pending_next = pending_reg;
        if (wen) begin
            if (pending_reg) begin
                // Delay slot already fetched: redirect now. A branch sitting in
                // the delay slot is not supported and is silently dropped.
                pc_next      = target_reg;
                pending_next = 1'b0;
            end else if (b_cond_met) begin
                pc_next      = pc_seq;
                target_next  = pc_in;
                pending_next = 1'b1;
            end else begin
                pc_next = pc_seq;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg      <= RESET_VECTOR;
            target_reg  <= 32'd0;
            pending_reg <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            target_reg  <= target_next;
            pending_reg <= pending_next;
        end
    end

    assign pc_o = pc_reg;

endmodule

// File: tb/tb_cpu_pc.sv
// Directed bench for cpu_pc: reset, sequential stepping, delayed branch, stalls and wrap.
module tb_cpu_pc;

    logic        clk;
    logic        reset;
    logic        wen;
    logic        b_cond_met;
    logic [31:0] pc_in;
    logic [31:0] pc_o;

    int checks;
    int errors;

    cpu_pc dut (
        .clk        (clk),
        .reset      (reset),
        .wen        (wen),
        .b_cond_met (b_cond_met),
        .pc_in      (pc_in),
        .pc_o       (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge, release, leaving pc_o at the boot vector.
    task automatic do_reset();
        reset      = 1'b1;
        wen        = 1'b1;
        b_cond_met = 1'b0;
        pc_in      = 32'd0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'hBFC00000; exp_seq[1] = 32'hBFC00004;
        exp_seq[2] = 32'hBFC00008; exp_seq[3] = 32'hBFC0000C;
        reset = 1'b1; wen = 1'b1; b_cond_met = 1'b0; pc_in = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc_o !== 32'hBFC00000) begin
                errors++;
                $display("FAIL reset_hold edge%0d pc_o=%08h expected=%08h", i, pc_o, 32'hBFC00000);
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if (pc_o !== exp_seq[i]) begin
                errors++;
                $display("FAIL reset_release step%0d pc_o=%08h expected=%08h", i, pc_o, exp_seq[i]);
            end
        end
        $display("test_reset done pc_o=%08h", pc_o);
    endtask

    task automatic test_mid_run_reset();
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pc_o !== 32'hBFC0000C) begin
            errors++;
            $display("FAIL midrun_pre pc_o=%08h expected=%08h", pc_o, 32'hBFC0000C);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (pc_o !== 32'hBFC00000) begin
            errors++;
            $display("FAIL midrun_async pc_o=%08h expected=%08h", pc_o, 32'hBFC00000);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc_o !== 32'hBFC00000) begin
                errors++;
                $display("FAIL midrun_hold edge%0d pc_o=%08h expected=%08h", i, pc_o, 32'hBFC00000);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (pc_o !== 32'hBFC00004) begin
            errors++;
            $display("FAIL midrun_restart pc_o=%08h expected=%08h", pc_o, 32'hBFC00004);
        end
        $display("test_mid_run_reset done pc_o=%08h", pc_o);
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (pc_o !== 32'hBFC00010) begin
            errors++;
            $display("FAIL branch_setup pc_o=%08h expected=%08h", pc_o, 32'hBFC00010);
        end
        b_cond_met = 1'b1; pc_in = 32'hAAA00000;
        tick();
        b_cond_met = 1'b0; pc_in = 32'h0;
        checks++;
        if (pc_o !== 32'hBFC00014) begin
            errors++;
            $display("FAIL branch_slot pc_o=%08h expected=%08h", pc_o, 32'hBFC00014);
        end
        tick();
        checks++;
        if (pc_o !== 32'hAAA00000) begin
            errors++;
            $display("FAIL branch_target pc_o=%08h expected=%08h", pc_o, 32'hAAA00000);
        end
        tick();
        checks++;
        if (pc_o !== 32'hAAA00004) begin
            errors++;
            $display("FAIL branch_after pc_o=%08h expected=%08h", pc_o, 32'hAAA00004);
        end
        $display("test_branch done pc_o=%08h", pc_o);
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc_o !== 32'hBFC00008) begin
                errors++;
                $display("FAIL stall_hold edge%0d pc_o=%08h expected=%08h", i, pc_o, 32'hBFC00008);
            end
        end
        b_cond_met = 1'b1; pc_in = 32'hAAA00000;
        tick();
        b_cond_met = 1'b0; pc_in = 32'h0;
        checks++;
        if (pc_o !== 32'hBFC00008) begin
            errors++;
            $display("FAIL stall_branch_hold pc_o=%08h expected=%08h", pc_o, 32'hBFC00008);
        end
        wen = 1'b1;
        tick(); tick();
        checks++;
        if (pc_o !== 32'hBFC00010) begin
            errors++;
            $display("FAIL stall_no_redirect pc_o=%08h expected=%08h", pc_o, 32'hBFC00010);
        end
        $display("test_stall done pc_o=%08h", pc_o);
    endtask

    task automatic test_stall_delay_slot();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        b_cond_met = 1'b1; pc_in = 32'hAAA00000;
        tick();
        b_cond_met = 1'b0; pc_in = 32'h0; wen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (pc_o !== 32'hBFC00014) begin
                errors++;
                $display("FAIL slot_stall edge%0d pc_o=%08h expected=%08h", i, pc_o, 32'hBFC00014);
            end
        end
        wen = 1'b1;
        tick();
        checks++;
        if (pc_o !== 32'hAAA00000) begin
            errors++;
            $display("FAIL slot_stall_redirect pc_o=%08h expected=%08h", pc_o, 32'hAAA00000);
        end
        $display("test_stall_delay_slot done pc_o=%08h", pc_o);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        b_cond_met = 1'b1; pc_in = 32'hAAA00000;
        tick();
        pc_in = 32'h12340000;
        tick();
        b_cond_met = 1'b0; pc_in = 32'h0;
        checks++;
        if (pc_o !== 32'hAAA00000) begin
            errors++;
            $display("FAIL b2b_first_target pc_o=%08h expected=%08h", pc_o, 32'hAAA00000);
        end
        tick();
        checks++;
        if (pc_o !== 32'hAAA00004) begin
            errors++;
            $display("FAIL b2b_dropped pc_o=%08h expected=%08h", pc_o, 32'hAAA00004);
        end
        $display("test_back_to_back done pc_o=%08h", pc_o);
    endtask

    task automatic test_wrap();
        do_reset();
        b_cond_met = 1'b1; pc_in = 32'hFFFFFFFC;
        tick();
        b_cond_met = 1'b0; pc_in = 32'h0;
        tick();
        checks++;
        if (pc_o !== 32'hFFFFFFFC) begin
            errors++;
            $display("FAIL wrap_setup pc_o=%08h expected=%08h", pc_o, 32'hFFFFFFFC);
        end
        tick();
        checks++;
        if (pc_o !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap_zero pc_o=%08h expected=%08h", pc_o, 32'h00000000);
        end
        tick();
        checks++;
        if (pc_o !== 32'h00000004) begin
            errors++;
            $display("FAIL wrap_next pc_o=%08h expected=%08h", pc_o, 32'h00000004);
        end
        $display("test_wrap done pc_o=%08h", pc_o);
    endtask

    task automatic test_reset_cancels_branch();
        do_reset();
        b_cond_met = 1'b1; pc_in = 32'h00400000;
        tick();
        b_cond_met = 1'b0; pc_in = 32'h0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        tick();
        checks++;
        if (pc_o !== 32'hBFC00004) begin
            errors++;
            $display("FAIL reset_cancel pc_o=%08h expected=%08h", pc_o, 32'hBFC00004);
        end
        $display("test_reset_cancels_branch done pc_o=%08h", pc_o);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; wen = 1'b0; b_cond_met = 1'b0; pc_in = 32'h0;
        test_reset();
        test_mid_run_reset();
        test_branch();
        test_stall();
        test_stall_delay_slot();
        test_back_to_back();
        test_wrap();
        test_reset_cancels_branch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
